// File: rtl/rr_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin arbiter and its encoders.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int STATS_CNT_W = 32;

  function automatic int idx_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/priority_encoder_tree.sv
// Lowest-set-bit priority encoder, combinational; IMPLEMENTATION=0 is a two-level
// group tree split SPLIT ways, any other value is a flat scan (identical results).
module priority_encoder_tree #(
  parameter int WIDTH          = 16,
  parameter int SPLIT          = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0]         req_i,
  output logic                     vld_o,
  output logic [$clog2(WIDTH)-1:0] idx_o
);

  localparam int IW   = $clog2(WIDTH);
  localparam int SP   = (SPLIT > WIDTH) ? WIDTH : ((SPLIT < 2) ? 2 : SPLIT);
  localparam int NGRP = WIDTH / SP;

  assign vld_o = |req_i;

  if (IMPLEMENTATION == 0) begin : g_tree
    logic [NGRP-1:0] grp_any;
    logic [SP-1:0]   grp_bits;
    int              sel_grp;
    int              sel_bit;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
      assign grp_any[g] = |req_i[g*SP +: SP];
    end

    // Pick the lowest non-empty group first, then the lowest bit inside it.
    always_comb begin
      sel_grp = 0;
      for (int g = NGRP - 1; g >= 0; g--) begin
        if (grp_any[g]) sel_grp = g;
      end
      grp_bits = req_i[sel_grp*SP +: SP];
      sel_bit  = 0;
      for (int b = SP - 1; b >= 0; b--) begin
        if (grp_bits[b]) sel_bit = b;
      end
      idx_o = IW'(sel_grp * SP + sel_bit);
    end
  end else begin : g_flat
    always_comb begin
      idx_o = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req_i[i]) idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered grant, 1-cycle latency, grant held stable under stall;
// optional grant counter output grt_cnt when ROUND_ROBIN_ARBITER_STATS_EN is defined.
module round_robin_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int SPLIT          = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              dec_vld,
  output logic                          grt_vld,
  input  logic                          grt_rdy,
  output logic [idx_width(WIDTH)-1:0]   grt_idx,
  output logic [WIDTH-1:0]              grt_oh
`ifdef ROUND_ROBIN_ARBITER_STATS_EN
  ,
  output logic [STATS_CNT_W-1:0]        grt_cnt
`endif
);

  localparam int IW = idx_width(WIDTH);

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] oh_q, oh_d;

  logic             hs;
  logic [IW-1:0]    ptr_eff;
  logic [WIDTH-1:0] masked;
  logic             m_vld, u_vld;
  logic [IW-1:0]    m_idx, u_idx;
  logic [IW-1:0]    win_idx;
  logic [WIDTH-1:0] win_oh;

  assign hs = (state_q == GRANT) && grt_rdy;

  // On a handshake the mask already uses the advanced pointer, giving 1 grant/cycle.
  assign ptr_eff = hs ? IW'(idx_q + 1'b1) : ptr_q;

  always_comb begin
    masked = '0;
    for (int i = 0; i < WIDTH; i++) begin
      masked[i] = dec_vld[i] && (i >= int'(ptr_eff));
    end
  end

  priority_encoder_tree #(
    .WIDTH         (WIDTH),
    .SPLIT         (SPLIT),
    .IMPLEMENTATION(IMPLEMENTATION)
  ) u_enc_masked (
    .req_i(masked),
    .vld_o(m_vld),
    .idx_o(m_idx)
  );

  priority_encoder_tree #(
    .WIDTH         (WIDTH),
    .SPLIT         (SPLIT),
    .IMPLEMENTATION(IMPLEMENTATION)
  ) u_enc_full (
    .req_i(dec_vld),
    .vld_o(u_vld),
    .idx_o(u_idx)
  );

  assign win_idx = m_vld ? m_idx : u_idx;
  assign win_oh  = WIDTH'(1) << win_idx;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    unique case (state_q)
      IDLE: begin
        if (u_vld) begin
          state_d = GRANT;
          idx_d   = win_idx;
          oh_d    = win_oh;
        end
      end
      GRANT: begin
        if (grt_rdy) begin
          ptr_d = ptr_eff;
          if (u_vld) begin
            idx_d = win_idx;
            oh_d  = win_oh;
          end else begin
            state_d = IDLE;
            oh_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        oh_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      oh_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
    end
  end

  assign grt_vld = (state_q == GRANT);
  assign grt_idx = idx_q;
  assign grt_oh  = oh_q;

`ifdef ROUND_ROBIN_ARBITER_STATS_EN
  logic [STATS_CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = hs ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign grt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter (WIDTH=16); counter checks when
// ROUND_ROBIN_ARBITER_STATS_EN is defined.
module tb_round_robin_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] dec_vld;
  logic        grt_vld;
  logic        grt_rdy;
  logic [3:0]  grt_idx;
  logic [15:0] grt_oh;
`ifdef ROUND_ROBIN_ARBITER_STATS_EN
  logic [31:0] grt_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  round_robin_arbiter #(
    .WIDTH         (16),
    .SPLIT         (4),
    .IMPLEMENTATION(0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dec_vld(dec_vld),
    .grt_vld(grt_vld),
    .grt_rdy(grt_rdy),
    .grt_idx(grt_idx),
    .grt_oh (grt_oh)
`ifdef ROUND_ROBIN_ARBITER_STATS_EN
    ,
    .grt_cnt(grt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input int exp_idx);
    logic [15:0] exp_oh;
    exp_oh = 16'h0001 << exp_idx;
    chk({tag, ".vld"}, {31'd0, grt_vld}, 32'd1);
    chk({tag, ".idx"}, {28'd0, grt_idx}, exp_idx);
    chk({tag, ".oh"},  {16'd0, grt_oh},  {16'd0, exp_oh});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".vld"}, {31'd0, grt_vld}, 32'd0);
    chk({tag, ".oh"},  {16'd0, grt_oh},  32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    dec_vld = 16'h0000;
    grt_rdy = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset.idx", {28'd0, grt_idx}, 32'd0);
`ifdef ROUND_ROBIN_ARBITER_STATS_EN
    chk("reset.cnt", grt_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // No requests: nothing granted for five cycles.
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_idle("idle");
    end

    // All requesting with rdy held: 0..15 then wrap to 0, one per cycle.
    dec_vld = 16'hFFFF;
    grt_rdy = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      chk_grant("sweep", k % 16);
    end

    // Two requesters at the extremes: 15, wrap to 0, back to 15.
    dec_vld = 16'h8001;
    tick();
    chk_grant("wrap.a", 15);
    tick();
    chk_grant("wrap.b", 0);
    tick();
    chk_grant("wrap.c", 15);

    // Handshake with no requests returns to idle.
    dec_vld = 16'h0000;
    tick();
    chk_idle("drain");

    // Stall holds grant 3 while requests change, then moves to 8.
    dec_vld = 16'h0008;
    grt_rdy = 1'b0;
    tick();
    chk_grant("stall.first", 3);
    dec_vld = 16'h0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_grant("stall.hold", 3);
    end
    grt_rdy = 1'b1;
    tick();
    chk_grant("stall.next", 8);

    // Sole requester is re-granted every cycle.
    dec_vld = 16'h0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_grant("sole", 4);
    end

    // Reset mid-grant drops grt_vld without a clock edge.
    dec_vld = 16'h0080;
    tick();
    chk_grant("pre_rst", 7);
    grt_rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst.idx", {28'd0, grt_idx}, 32'd0);
    dec_vld = 16'h00FF;
    tick();
    rst_n = 1'b1;
`ifdef ROUND_ROBIN_ARBITER_STATS_EN
    chk("post_rst.cnt", grt_cnt, 32'd0);
`endif
    tick();
    chk_grant("post_rst", 0);

`ifdef ROUND_ROBIN_ARBITER_STATS_EN
    chk("cnt.0", grt_cnt, 32'd0);
    grt_rdy = 1'b1;
    tick();
    chk_grant("cnt.g1", 1);
    chk("cnt.1", grt_cnt, 32'd1);
    tick();
    chk_grant("cnt.g2", 2);
    chk("cnt.2", grt_cnt, 32'd2);
    grt_rdy = 1'b0;
    tick();
    chk("cnt.stall", grt_cnt, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
